dice_roll_ctrl: RTL and testbench

//  Roll controller fed by the tick strobe of the upstream counter chain. While ROLL_BTN is held, the die face

---
 rtl/dice_pkg.sv | 20 ++
 rtl/dice_roll_ctrl_if.sv | 36 +++
 rtl/die_stepper.sv | 33 +++
 rtl/dice_roll_ctrl.sv | 117 +++++++++++
 tb/tb_dice_roll_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dice_pkg.sv
// Shared constants for the dice roll controller and the downstream display decoder.
// Latency: none (constants only).
// Backpressure: none.
package dice_pkg;

    // Width of the face value carried on DIE_VALUE
    localparam int FACE_W      = 3;

    // Face range shared with the display decoder
    localparam int DIE_MIN     = 1;
    localparam int DIE_MAX_DEF = 6;

    // Roll controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SPIN = 2'd1;
    localparam state_t ST_SLOW = 2'd2;
    localparam state_t ST_SHOW = 2'd3;

endpackage

// File: rtl/dice_roll_ctrl_if.sv
// Groups the tick/button inputs and face/status outputs of the roll controller.
// Latency: none (wiring only).
// Backpressure: none; TICK is a strobe, all outputs are levels or one-cycle pulses.
interface dice_roll_ctrl_if #(
    parameter int RCNT_WIDTH = 8
);
    import dice_pkg::*;

    logic                  TICK;
    logic                  ROLL_BTN;
    logic [FACE_W-1:0]     DIE_VALUE;
    logic                  ROLLING;
    logic                  DONE;
    logic [RCNT_WIDTH-1:0] ROLL_COUNT;

    // Stimulus side: counter chain and button conditioner
    modport master (
        output TICK,
        output ROLL_BTN,
        input  DIE_VALUE,
        input  ROLLING,
        input  DONE,
        input  ROLL_COUNT
    );

    // Roll controller side
    modport slave (
        input  TICK,
        input  ROLL_BTN,
        output DIE_VALUE,
        output ROLLING,
        output DONE,
        output ROLL_COUNT
    );

endinterface

// File: rtl/die_stepper.sv
// Face register: advances one face per ADV, wrapping DIE_MAX back to DIE_MIN; CLR forces DIE_MIN.
// Latency: new face visible one cycle after ADV/CLR.
// Backpressure: none; CLR has priority over ADV.
module die_stepper
    import dice_pkg::*;
#(
    parameter int DIE_MAX = DIE_MAX_DEF
) (
    input  logic              CLK,
    input  logic              ADV,
    input  logic              CLR,
    output logic [FACE_W-1:0] FACE
);

    logic [FACE_W-1:0] r_face;

    // Clear to the lowest face, otherwise step and wrap; anything at or above DIE_MAX wraps so no
    // out-of-range face can persist
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_face <= FACE_W'(DIE_MIN);
        end else if (ADV) begin
            if (r_face >= FACE_W'(DIE_MAX)) begin
                r_face <= FACE_W'(DIE_MIN);
            end else begin
                r_face <= r_face + 1'b1;
            end
        end
    end

    assign FACE = r_face;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll controller: spins the face per TICK while the button is held, decelerates after release, latches result.
// Latency: face advance, ROLLING and DONE all appear one cycle after the qualifying input.
// Backpressure: none; TICK strobes are consumed every cycle they arrive, ignored in IDLE/SHOW.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int DIE_MAX       = DIE_MAX_DEF,
    parameter int SLOW_STEPS    = 5,
    parameter int INTERVAL_INIT = 2,
    parameter int INTERVAL_INC  = 2,
    parameter int IVL_WIDTH     = 5,
    parameter int RCNT_WIDTH    = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    dice_roll_ctrl_if.slave  bus
);

    state_t                r_state;
    logic                  r_btn_d;
    logic                  r_rolling;
    logic                  r_done;
    logic [RCNT_WIDTH-1:0] r_roll_count;
    logic [IVL_WIDTH-1:0]  r_interval;
    logic [IVL_WIDTH-1:0]  r_tick_cnt;
    logic [IVL_WIDTH-1:0]  r_steps;

    logic                  w_press;
    logic                  w_ivl_hit;
    logic                  w_spin_adv;
    logic                  w_slow_adv;
    logic                  w_adv;
    logic [FACE_W-1:0]     w_face;

    // Rising edge of the conditioned button level
    assign w_press    = bus.ROLL_BTN & ~r_btn_d;

    // Last tick of the current slow interval
    assign w_ivl_hit  = (r_tick_cnt == (r_interval - IVL_WIDTH'(1)));

    // In the release cycle the SPIN->SLOW transition wins over a coincident TICK
    assign w_spin_adv = (r_state == ST_SPIN) & bus.ROLL_BTN & bus.TICK;
    assign w_slow_adv = (r_state == ST_SLOW) & bus.TICK & w_ivl_hit;
    assign w_adv      = w_spin_adv | w_slow_adv;

    die_stepper #(
        .DIE_MAX (DIE_MAX)
    ) u_stepper (
        .CLK  (CLK),
        .ADV  (w_adv),
        .CLR  (RESET),
        .FACE (w_face)
    );

    // Roll FSM with button edge register, deceleration counters and saturating roll counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_btn_d      <= 1'b0;
            r_rolling    <= 1'b0;
            r_done       <= 1'b0;
            r_roll_count <= '0;
            r_interval   <= '0;
            r_tick_cnt   <= '0;
            r_steps      <= '0;
        end else begin
            r_btn_d <= bus.ROLL_BTN;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_SHOW: begin
                    if (w_press) begin
                        r_state   <= ST_SPIN;
                        r_rolling <= 1'b1;
                    end
                end
                ST_SPIN: begin
                    if (!bus.ROLL_BTN) begin
                        r_state    <= ST_SLOW;
                        r_interval <= IVL_WIDTH'(INTERVAL_INIT);
                        r_tick_cnt <= '0;
                        r_steps    <= '0;
                    end
                end
                ST_SLOW: begin
                    // Button is deliberately ignored while decelerating
                    if (bus.TICK) begin
                        if (w_ivl_hit) begin
                            r_tick_cnt <= '0;
                            r_interval <= r_interval + IVL_WIDTH'(INTERVAL_INC);
                            r_steps    <= r_steps + 1'b1;
                            if (r_steps == IVL_WIDTH'(SLOW_STEPS - 1)) begin
                                r_state   <= ST_SHOW;
                                r_done    <= 1'b1;
                                r_rolling <= 1'b0;
                                if (r_roll_count != '1) begin
                                    r_roll_count <= r_roll_count + 1'b1;
                                end
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rolling <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DIE_VALUE  = w_face;
    assign bus.ROLLING    = r_rolling;
    assign bus.DONE       = r_done;
    assign bus.ROLL_COUNT = r_roll_count;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: directed scenarios plus randomized button/tick traffic against a roll-level model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_dice_roll_ctrl;
    import dice_pkg::*;

    localparam int DMAX       = 6;
    localparam int SLOW_STEPS = 5;
    localparam int IVL_INIT   = 2;
    localparam int IVL_INC    = 2;
    localparam int CNT_MAX    = 255;

    localparam int M_IDLE = 0;
    localparam int M_SPIN = 1;
    localparam int M_SLOW = 2;
    localparam int M_SHOW = 3;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    dice_roll_ctrl_if #(.RCNT_WIDTH(8)) ifc ();

    dice_roll_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ifc)
    );

    int n_err = 0;
    int n_chk = 0;

    // Roll-level model: which phase of a roll we are in, and how many ticks remain before the next slow advance
    int m_mode;
    int m_face;
    int m_count;
    int m_slow_idx;
    int m_ticks_left;
    bit m_rolling;
    bit m_done;
    bit m_prev_btn;

    function automatic void m_step(input bit rst, input bit btn, input bit tick);
        bit press;
        if (rst) begin
            m_mode     = M_IDLE;
            m_face     = 1;
            m_rolling  = 1'b0;
            m_done     = 1'b0;
            m_count    = 0;
            m_prev_btn = 1'b0;
        end else begin
            press  = btn && !m_prev_btn;
            m_done = 1'b0;
            case (m_mode)
                M_IDLE, M_SHOW: begin
                    if (press) begin
                        m_mode    = M_SPIN;
                        m_rolling = 1'b1;
                    end
                end
                M_SPIN: begin
                    if (!btn) begin
                        m_mode       = M_SLOW;
                        m_slow_idx   = 0;
                        m_ticks_left = IVL_INIT;
                    end else if (tick) begin
                        m_face = (m_face % DMAX) + 1;
                    end
                end
                default: begin
                    if (tick) begin
                        m_ticks_left = m_ticks_left - 1;
                        if (m_ticks_left == 0) begin
                            m_face     = (m_face % DMAX) + 1;
                            m_slow_idx = m_slow_idx + 1;
                            if (m_slow_idx == SLOW_STEPS) begin
                                m_mode    = M_SHOW;
                                m_done    = 1'b1;
                                m_rolling = 1'b0;
                                if (m_count < CNT_MAX) m_count = m_count + 1;
                            end else begin
                                m_ticks_left = IVL_INIT + m_slow_idx * IVL_INC;
                            end
                        end
                    end
                end
            endcase
            m_prev_btn = btn;
        end
    endfunction

    // One clock cycle with the given inputs; model tracks the same edge
    task automatic cyc(input bit rst, input bit btn, input bit tick);
        RESET        = rst;
        ifc.ROLL_BTN = btn;
        ifc.TICK     = tick;
        @(posedge CLK);
        m_step(rst, btn, tick);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'($urandom % 2), 1'($urandom % 2));
        cyc(1'b1, 1'b0, 1'($urandom % 2));
        n_chk++; if (ifc.DIE_VALUE !== 3'd1) begin n_err++; $display("FAIL reset_face got=%0d exp=1", ifc.DIE_VALUE); end
        n_chk++; if (ifc.ROLLING !== 1'b0) begin n_err++; $display("FAIL reset_rolling got=%b exp=0", ifc.ROLLING); end
        n_chk++; if (ifc.DONE !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", ifc.DONE); end
        n_chk++; if (ifc.ROLL_COUNT !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", ifc.ROLL_COUNT); end
    endtask

    task automatic test_spin_wrap();
        int exp_face[6] = '{2, 3, 4, 5, 6, 1};
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        n_chk++; if (ifc.ROLLING !== 1'b1) begin n_err++; $display("FAIL spin_start_rolling got=%b exp=1", ifc.ROLLING); end
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b1);
            n_chk++; if (ifc.DIE_VALUE !== 3'(exp_face[i])) begin n_err++; $display("FAIL spin_face[%0d] got=%0d exp=%0d", i, ifc.DIE_VALUE, exp_face[i]); end
            n_chk++; if (ifc.ROLLING !== 1'b1) begin n_err++; $display("FAIL spin_rolling[%0d] got=%b exp=1", i, ifc.ROLLING); end
        end
    endtask

    task automatic test_full_roll();
        int exp;
        int dones = 0;
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        n_chk++; if (ifc.DIE_VALUE !== 3'd4) begin n_err++; $display("FAIL full_hold_face got=%0d exp=4", ifc.DIE_VALUE); end
        cyc(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            exp = 4 + int'(k >= 2) + int'(k >= 6) + int'(k >= 12) + int'(k >= 20) + int'(k >= 30);
            exp = ((exp - 1) % DMAX) + 1;
            n_chk++; if (ifc.DIE_VALUE !== 3'(exp)) begin n_err++; $display("FAIL full_face_tick%0d got=%0d exp=%0d", k, ifc.DIE_VALUE, exp); end
            if (ifc.DONE === 1'b1) dones++;
        end
        n_chk++; if (ifc.DONE !== 1'b1) begin n_err++; $display("FAIL full_done_after_tick30 got=%b exp=1", ifc.DONE); end
        cyc(1'b0, 1'b0, 1'b0);
        if (ifc.DONE === 1'b1) dones++;
        n_chk++; if (dones !== 1) begin n_err++; $display("FAIL full_done_pulses got=%0d exp=1", dones); end
        n_chk++; if (ifc.DIE_VALUE !== 3'd3) begin n_err++; $display("FAIL full_final_face got=%0d exp=3", ifc.DIE_VALUE); end
        n_chk++; if (ifc.ROLL_COUNT !== 8'd1) begin n_err++; $display("FAIL full_count got=%0d exp=1", ifc.ROLL_COUNT); end
        n_chk++; if (ifc.ROLLING !== 1'b0) begin n_err++; $display("FAIL full_rolling got=%b exp=0", ifc.ROLLING); end
    endtask

    task automatic test_release_tick();
        bit btn;
        bit tick;
        int guard;
        logic [2:0] held_face;
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        n_chk++; if (ifc.DIE_VALUE !== 3'd3) begin n_err++; $display("FAIL release_tick_face got=%0d exp=3", ifc.DIE_VALUE); end
        n_chk++; if (ifc.ROLLING !== 1'b1) begin n_err++; $display("FAIL release_tick_rolling got=%b exp=1", ifc.ROLLING); end
        // Button chatter during deceleration must not disturb it
        for (int i = 0; i < 12; i++) begin
            btn  = 1'($urandom % 2);
            tick = 1'($urandom % 2);
            cyc(1'b0, btn, tick);
            n_chk++;
            if ({ifc.DIE_VALUE, ifc.ROLLING, ifc.DONE} !== {3'(m_face), m_rolling, m_done}) begin
                n_err++;
                $display("FAIL slow_press_ignored[%0d] got=%0d/%b/%b exp=%0d/%b/%b", i, ifc.DIE_VALUE, ifc.ROLLING, ifc.DONE, m_face, m_rolling, m_done);
            end
        end
        // Hold the button until the roll ends
        guard = 0;
        while (m_mode == M_SLOW && guard < 200) begin
            cyc(1'b0, 1'b1, 1'b1);
            guard++;
        end
        n_chk++; if (ifc.DONE !== 1'b1 || guard >= 200) begin n_err++; $display("FAIL hold_roll_done got=%b exp=1 cycles=%0d", ifc.DONE, guard); end
        held_face = ifc.DIE_VALUE;
        n_chk++; if (held_face !== 3'(m_face)) begin n_err++; $display("FAIL hold_final_face got=%0d exp=%0d", held_face, m_face); end
        repeat (5) cyc(1'b0, 1'b1, 1'b1);
        n_chk++; if (ifc.ROLLING !== 1'b0) begin n_err++; $display("FAIL show_hold_rolling got=%b exp=0", ifc.ROLLING); end
        n_chk++; if (ifc.DIE_VALUE !== held_face) begin n_err++; $display("FAIL show_hold_face got=%0d exp=%0d", ifc.DIE_VALUE, held_face); end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        n_chk++; if (ifc.ROLLING !== 1'b1) begin n_err++; $display("FAIL show_repress_rolling got=%b exp=1", ifc.ROLLING); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b1);
        n_chk++; if (ifc.DIE_VALUE !== 3'd6) begin n_err++; $display("FAIL mid_face_before got=%0d exp=6", ifc.DIE_VALUE); end
        cyc(1'b1, 1'b0, 1'b1);
        n_chk++; if (ifc.DIE_VALUE !== 3'd1) begin n_err++; $display("FAIL mid_reset_face got=%0d exp=1", ifc.DIE_VALUE); end
        n_chk++; if (ifc.ROLLING !== 1'b0) begin n_err++; $display("FAIL mid_reset_rolling got=%b exp=0", ifc.ROLLING); end
        n_chk++; if (ifc.ROLL_COUNT !== 8'd0) begin n_err++; $display("FAIL mid_reset_count got=%0d exp=0", ifc.ROLL_COUNT); end
        // Idle ticks afterwards must not resume the roll
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (ifc.DONE === 1'b1) dones++;
        end
        n_chk++; if (dones !== 0) begin n_err++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
        n_chk++; if (ifc.DIE_VALUE !== 3'd1) begin n_err++; $display("FAIL mid_idle_face got=%0d exp=1", ifc.DIE_VALUE); end
    endtask

    task automatic test_saturation();
        int exp;
        do_reset();
        for (int r = 1; r <= 256; r++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            repeat (30) cyc(1'b0, 1'b0, 1'b1);
            exp = (r > CNT_MAX) ? CNT_MAX : r;
            n_chk++; if (ifc.ROLL_COUNT !== 8'(exp)) begin n_err++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", r, ifc.ROLL_COUNT, exp); end
        end
    endtask

    task automatic test_no_tick_spin();
        int changes = 0;
        logic [2:0] start_face;
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        start_face = ifc.DIE_VALUE;
        repeat (1000) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (ifc.DIE_VALUE !== start_face) changes++;
        end
        n_chk++; if (changes !== 0 || start_face !== 3'd1) begin n_err++; $display("FAIL no_tick_face changes=%0d face=%0d exp=0 changes face 1", changes, start_face); end
        n_chk++; if (ifc.ROLLING !== 1'b1) begin n_err++; $display("FAIL no_tick_rolling got=%b exp=1", ifc.ROLLING); end
    endtask

    task automatic test_random();
        bit btn = 1'b0;
        bit tick;
        bit rst;
        int seg = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                btn = ~btn;
                seg = $urandom_range(1, 50);
            end
            seg--;
            tick = ($urandom % 3) == 0;
            rst  = ($urandom % 600) == 0;
            cyc(rst, btn, tick);
            n_chk++;
            if ({ifc.DIE_VALUE, ifc.ROLLING, ifc.DONE, ifc.ROLL_COUNT} !== {3'(m_face), m_rolling, m_done, 8'(m_count)}) begin
                n_err++;
                $display("FAIL random[%0d] got=%0d/%b/%b/%0d exp=%0d/%b/%b/%0d", i, ifc.DIE_VALUE, ifc.ROLLING, ifc.DONE, ifc.ROLL_COUNT, m_face, m_rolling, m_done, m_count);
            end
        end
    endtask

    initial begin
        ifc.TICK     = 1'b0;
        ifc.ROLL_BTN = 1'b0;
        RESET        = 1'b1;
        test_reset();
        test_spin_wrap();
        test_full_roll();
        test_release_tick();
        test_reset_mid();
        test_no_tick_spin();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
